// File: rtl/conv55_ctrl.sv
// Sequencer for a 5x5 sliding-window convolver: accepts source columns, tracks
// column/stripe position and flags full-window results with their coordinates.
module conv55_ctrl #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          col_valid,
    output logic          col_ready,
    output logic          conv_en,
    output logic [CW-1:0] src_col,
    output logic [CW-1:0] src_stripe,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_col,
    output logic [CW-1:0] out_row
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [CW-1:0] LAST_COL    = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_STRIPE = CW'(IMG_H - 5);
    localparam logic [CW-1:0] FIRST_OUT   = CW'(4);

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_stripe;
    logic [CW-1:0] r_out_col;
    logic [CW-1:0] r_out_row;
    logic          r_out_valid;
    logic          r_busy;
    logic          r_done;
    logic          w_hold;
    logic          w_accept;

    // A pending result that downstream has not taken freezes the window.
    assign w_hold    = r_out_valid & ~out_ready;
    assign col_ready = (r_state == S_RUN) & ~w_hold;
    assign w_accept  = col_valid & col_ready;
    assign conv_en   = w_accept;

    assign busy       = r_busy;
    assign done       = r_done;
    assign src_col    = r_col;
    assign src_stripe = r_stripe;
    assign out_valid  = r_out_valid;
    assign out_col    = r_out_col;
    assign out_row    = r_out_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_stripe    <= '0;
            r_out_col   <= '0;
            r_out_row   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // A new full window replaces a consumed one without a bubble.
            if (w_accept && (r_col >= FIRST_OUT)) begin
                r_out_valid <= 1'b1;
                r_out_col   <= r_col - FIRST_OUT;
                r_out_row   <= r_stripe;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_col    <= '0;
                        r_stripe <= '0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_col == LAST_COL) begin
                            if (r_stripe == LAST_STRIPE) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_col    <= '0;
                                r_stripe <= r_stripe + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_out_valid || out_ready) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv55_ctrl.sv
// Directed bench for conv55_ctrl on an 8x6 frame: a per-cycle vector table for
// one full frame, then hand-written back-pressure, gap, and mid-frame reset runs.
module tb_conv55_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          col_valid;
    logic          col_ready;
    logic          conv_en;
    logic [CW-1:0] src_col;
    logic [CW-1:0] src_stripe;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_col;
    logic [CW-1:0] out_row;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv55_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .col_valid(col_valid), .col_ready(col_ready), .conv_en(conv_en),
        .src_col(src_col), .src_stripe(src_stripe), .out_valid(out_valid),
        .out_ready(out_ready), .out_col(out_col), .out_row(out_row)
    );

    typedef struct {
        logic st, cv, ordy;
        logic e_busy, e_crdy, e_cen, e_ov, e_done;
        int   e_oc, e_orow, e_sc, e_ss;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic st, cv, ordy, b, cr, ce, ov,
                                input int oc, orow, input logic dn, input int sc, ss);
        vec_t v;
        v.st = st; v.cv = cv; v.ordy = ordy;
        v.e_busy = b; v.e_crdy = cr; v.e_cen = ce; v.e_ov = ov; v.e_done = dn;
        v.e_oc = oc; v.e_orow = orow; v.e_sc = sc; v.e_ss = ss;
        return v;
    endfunction

    task automatic check(input string name, input bit ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [68:0] pack_act();
        return {busy, col_ready, conv_en, out_valid, done, out_col, out_row, src_col, src_stripe};
    endfunction

    // One frame with col_valid/out_ready patterns; checks coordinates, counts, done.
    task automatic run_frame(input bit gap, input bit bp, input string name);
        int  n_out = 0, n_en = 0, n_done = 0, bad_en = 0, bp_left = 0, rel_cyc = -1;
        bit  bp_started = 0;
        start = 1; col_valid = 1; out_ready = 1;
        #6; @(posedge clk); #1;
        start = 0;
        for (int cyc = 0; cyc < 300 && n_done == 0; cyc++) begin
            col_valid = gap ? ((cyc % 2) == 0) : 1'b1;
            if (bp && !bp_started && out_valid) begin
                bp_started = 1;
                bp_left = 3;
            end
            out_ready = (bp_left > 0) ? 1'b0 : 1'b1;
            #6;
            if (bp_left > 0) begin
                check({name, "_bp_hold"}, out_valid && out_col == 0 && !col_ready && !conv_en,
                      {out_valid, col_ready, conv_en, out_col[3:0]}, 7'b1000000);
                bp_left--;
                if (bp_left == 0) rel_cyc = cyc + 2;
            end
            if (cyc == rel_cyc)
                check({name, "_bp_release_col"}, out_valid && out_col == 1, int'(out_col), 1);
            if (out_valid && out_ready) begin
                check({name, "_coord"}, out_row == (n_out / 4) && out_col == (n_out % 4),
                      int'(out_row) * 100 + int'(out_col), (n_out / 4) * 100 + (n_out % 4));
                $display("%s out %0d row=%0d col=%0d", name, n_out, out_row, out_col);
                n_out++;
            end
            if (conv_en) n_en++;
            if (conv_en && !col_valid) bad_en++;
            if (done) n_done++;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            #6;
            if (done) n_done++;
            check({name, "_busy_after"}, busy == 1'b0, busy, 0);
            @(posedge clk); #1;
        end
        check({name, "_done_count"}, n_done == 1, n_done, 1);
        check({name, "_out_count"}, n_out == 8, n_out, 8);
        check({name, "_conv_en_count"}, n_en == 16, n_en, 16);
        check({name, "_conv_en_gap"}, bad_en == 0, bad_en, 0);
        if (bp) check({name, "_bp_seen"}, bp_started, bp_started, 1);
    endtask

    initial begin
        logic [68:0] exp_v;
        int n_en;
        bit hit;
        rst = 1; start = 0; col_valid = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #6;
        check("reset_state", pack_act() == '0, int'(pack_act() != '0), 0);
        @(posedge clk); #1;

        //             st cv or  b  cr ce ov oc r  dn sc ss
        tbl[0]  = mk(1, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 1, 1,  1, 1, 1, 0, 0, 0, 0, 2, 0);
        tbl[4]  = mk(0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 3, 0);
        tbl[5]  = mk(0, 1, 1,  1, 1, 1, 0, 0, 0, 0, 4, 0);
        tbl[6]  = mk(0, 1, 1,  1, 1, 1, 1, 0, 0, 0, 5, 0);
        tbl[7]  = mk(0, 1, 1,  1, 1, 1, 1, 1, 0, 0, 6, 0);
        tbl[8]  = mk(0, 1, 1,  1, 1, 1, 1, 2, 0, 0, 7, 0);
        tbl[9]  = mk(0, 1, 1,  1, 1, 1, 1, 3, 0, 0, 0, 1);
        tbl[10] = mk(0, 1, 1,  1, 1, 1, 0, 3, 0, 0, 1, 1);
        tbl[11] = mk(0, 1, 1,  1, 1, 1, 0, 3, 0, 0, 2, 1);
        tbl[12] = mk(0, 1, 1,  1, 1, 1, 0, 3, 0, 0, 3, 1);
        tbl[13] = mk(0, 1, 1,  1, 1, 1, 0, 3, 0, 0, 4, 1);
        tbl[14] = mk(0, 1, 1,  1, 1, 1, 1, 0, 1, 0, 5, 1);
        tbl[15] = mk(0, 1, 1,  1, 1, 1, 1, 1, 1, 0, 6, 1);
        tbl[16] = mk(0, 1, 1,  1, 1, 1, 1, 2, 1, 0, 7, 1);
        tbl[17] = mk(0, 1, 1,  1, 0, 0, 1, 3, 1, 0, 7, 1);
        tbl[18] = mk(0, 1, 1,  0, 0, 0, 0, 3, 1, 1, 7, 1);
        tbl[19] = mk(0, 1, 1,  0, 0, 0, 0, 3, 1, 0, 7, 1);

        for (int i = 0; i < 20; i++) begin
            start = tbl[i].st; col_valid = tbl[i].cv; out_ready = tbl[i].ordy;
            #6;
            exp_v = {tbl[i].e_busy, tbl[i].e_crdy, tbl[i].e_cen, tbl[i].e_ov, tbl[i].e_done,
                     CW'(tbl[i].e_oc), CW'(tbl[i].e_orow), CW'(tbl[i].e_sc), CW'(tbl[i].e_ss)};
            checks++;
            if (pack_act() !== exp_v) begin
                failures++;
                $display("FAIL vec_%0d actual=%h required=%h", i, pack_act(), exp_v);
            end else begin
                $display("vec %0d busy=%0d rdy=%0d en=%0d ov=%0d (%0d,%0d) done=%0d src=(%0d,%0d)",
                         i, busy, col_ready, conv_en, out_valid, out_row, out_col, done,
                         src_stripe, src_col);
            end
            @(posedge clk); #1;
        end
        start = 0;

        run_frame(1'b0, 1'b1, "backpressure");
        run_frame(1'b1, 1'b0, "gaps");

        // Reset asserted during the cycle of the 6th accept.
        start = 1; col_valid = 1; out_ready = 1;
        #6; @(posedge clk); #1;
        start = 0;
        n_en = 0; hit = 0;
        for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
            #6;
            if (conv_en) begin
                n_en++;
                if (n_en == 6) begin
                    rst = 1; #1;
                    check("reset_midframe_outputs", pack_act() == '0, int'(pack_act() != '0), 0);
                    hit = 1;
                end
            end
            @(posedge clk); #1;
        end
        check("reset_midframe_reached", hit, hit, 1);
        rst = 0;
        #6;
        check("reset_idle_no_ready", !busy && !col_ready && !done, {busy, col_ready, done}, 0);
        @(posedge clk); #1;
        run_frame(1'b0, 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
